// File: rtl/key_schedule_seq.sv
// key_schedule_seq
// Sequential AES-128 key expansion. A cipher key is latched on start and
// presented as round key 0. Each honoured next request derives the following
// round key in two cycles: one cycle for the registered S-box read of
// RotWord(w3), then one cycle to fold the four words together.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse: latch key and restart the schedule
//   key        128-bit cipher key, FIPS-197 byte order (key[127:120] = byte 0)
//   next       request the next round key (honoured only while key_valid=1)
//   round_key  current round key, same byte ordering as key
//   round      index of round_key, 0..10
//   key_valid  round_key/round are stable and usable
//   last       key_valid && round == 10
module key_schedule_seq #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         key_valid,
    output logic         last
);

    // Only the AES-128 schedule is implemented; any other round count is a
    // configuration error caught at elaboration.
    if (NR != 10) begin : g_nr_check
        $error("key_schedule_seq: only NR=10 (AES-128) is supported");
    end

    typedef enum logic [1:0] {
        IDLE,
        READY,
        SUB,
        EXPAND
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for the round being produced (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q;
    logic [127:0]   round_key_q;
    logic [3:0]     round_q;
    logic           key_valid_q;
    logic [31:0]    sbox_q;
    logic [7:0]     rcon_q;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_w3;
    logic [31:0]    sub_d;
    logic [31:0]    t, w0_d, w1_d, w2_d, w3_d;
    logic [127:0]   round_key_d;

    // Split the current key into its four columns. round_key_q is stable
    // through SUB and EXPAND, so it can address the S-box read directly.
    always_comb begin
        w0 = round_key_q[127:96];
        w1 = round_key_q[95:64];
        w2 = round_key_q[63:32];
        w3 = round_key_q[31:0];
        rot_w3 = {w3[23:0], w3[31:24]};
        sub_d = {SBOX[rot_w3[31:24]], SBOX[rot_w3[23:16]],
                 SBOX[rot_w3[15:8]],  SBOX[rot_w3[7:0]]};
    end

    // Combine the registered SubWord with Rcon and ripple the XOR chain
    // across the four words to form the next round key.
    always_comb begin
        t    = sbox_q ^ {rcon_q, 24'h0};
        w0_d = w0 ^ t;
        w1_d = w1 ^ w0_d;
        w2_d = w2 ^ w1_d;
        w3_d = w3 ^ w2_d;
        round_key_d = {w0_d, w1_d, w2_d, w3_d};
    end

    // Control FSM and all output registers. start overrides everything,
    // abandoning any expansion in flight; next is only acted on in READY
    // below the final round, so requests arriving elsewhere are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_q     <= '0;
            key_valid_q <= 1'b0;
            sbox_q      <= '0;
            rcon_q      <= '0;
        end else if (start) begin
            state_q     <= READY;
            round_key_q <= key;
            round_q     <= '0;
            key_valid_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                end
                READY: begin
                    if (next && (round_q != 4'(NR))) begin
                        key_valid_q <= 1'b0;
                        rcon_q      <= rcon(round_q + 4'd1);
                        state_q     <= SUB;
                    end
                end
                SUB: begin
                    sbox_q  <= sub_d;
                    state_q <= EXPAND;
                end
                EXPAND: begin
                    round_key_q <= round_key_d;
                    round_q     <= round_q + 4'd1;
                    key_valid_q <= 1'b1;
                    state_q     <= READY;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign round_key = round_key_q;
    assign round     = round_q;
    assign key_valid = key_valid_q;
    assign last      = key_valid_q && (round_q == 4'd10);

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq
// Self-checking bench for key_schedule_seq. Expected round keys come from the
// FIPS-197 key expansion example held in a local table; every start/next
// pushes its expected result onto a scoreboard queue that is popped when the
// DUT raises key_valid.
module tb_key_schedule_seq;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         key_valid;
    logic         last;

    int   checks;
    int   errors;
    vec_t fipsTable [0:10];
    vec_t sb [$];

    key_schedule_seq #(.NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .next      (next),
        .round_key (round_key),
        .round     (round),
        .key_valid (key_valid),
        .last      (last)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus thread.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expected result and compare it with the DUT outputs.
    task automatic popAndCompare(input string name);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got round %0d", name, round);
            return;
        end
        e = sb.pop_front();
        checkOutput({name, " key"}, round_key, e.key);
        checkOutput({name, " round"}, 128'(round), 128'(e.round));
        checkOutput({name, " valid"}, 128'(key_valid), 128'(1'b1));
        checkOutput({name, " last"}, 128'(last), 128'(e.round == 4'd10));
    endtask

    // Latch a key and expect round 0 on the following cycle.
    task automatic applyStimulus(input string name, input logic [127:0] k);
        vec_t e;
        e.round = 4'd0;
        e.key   = k;
        sb.push_back(e);
        key   = k;
        start = 1'b1;
        tick;
        start = 1'b0;
        popAndCompare(name);
    endtask

    // Issue one next pulse, measure how long key_valid is low, then compare.
    task automatic applyNext(input string name, input vec_t e);
        int lowCycles;
        sb.push_back(e);
        next = 1'b1;
        tick;
        next = 1'b0;
        lowCycles = 0;
        while (!key_valid && lowCycles < 10) begin
            lowCycles++;
            tick;
        end
        checkOutput({name, " latency"}, 128'(lowCycles), 128'(2));
        popAndCompare(name);
    endtask

    initial begin
        vec_t e;
        logic prevValid;
        logic [127:0] fipsKey;

        checks = 0;
        errors = 0;
        fipsTable[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        fipsTable[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        fipsTable[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        fipsTable[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        fipsTable[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        fipsTable[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        fipsTable[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        fipsTable[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        fipsTable[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        fipsTable[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        fipsTable[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        fipsKey = fipsTable[0].key;

        reset = 1'b1;
        start = 1'b0;
        next  = 1'b0;
        key   = 128'h0123456789abcdef0123456789abcdef;

        // Reset state, and next ignored while idle.
        repeat (3) tick;
        checkOutput("reset key", round_key, 128'h0);
        checkOutput("reset round", 128'(round), 128'h0);
        checkOutput("reset valid", 128'(key_valid), 128'h0);
        checkOutput("reset last", 128'(last), 128'h0);
        reset = 1'b0;
        tick;
        next = 1'b1;
        tick;
        next = 1'b0;
        repeat (3) tick;
        checkOutput("idle next valid", 128'(key_valid), 128'h0);
        checkOutput("idle next key", round_key, 128'h0);

        // Full FIPS-197 schedule, one next per valid key.
        applyStimulus("fips r0", fipsKey);
        key = 128'hffffffffffffffffffffffffffffffff;
        for (int r = 1; r <= 10; r++) begin
            applyNext($sformatf("fips r%0d", r), fipsTable[r]);
        end

        // Extra next at round 10 is ignored.
        next = 1'b1;
        tick;
        next = 1'b0;
        repeat (3) tick;
        checkOutput("extra next round", 128'(round), 128'(10));
        checkOutput("extra next key", round_key, fipsTable[10].key);
        checkOutput("extra next valid", 128'(key_valid), 128'h1);
        checkOutput("extra next last", 128'(last), 128'h1);

        // next held high: one advance per READY sample, no skipped rounds.
        applyStimulus("held r0", fipsKey);
        for (int r = 1; r <= 3; r++) sb.push_back(fipsTable[r]);
        prevValid = 1'b1;
        next = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick;
            if (key_valid && !prevValid) popAndCompare($sformatf("held cycle %0d", i));
            prevValid = key_valid;
        end
        next = 1'b0;
        checkOutput("held scoreboard drained", 128'(sb.size()), 128'h0);
        repeat (2) tick;
        checkOutput("held final round", 128'(round), 128'(3));

        // Restart with key 0 one cycle after a next (expansion abandoned).
        next = 1'b1;
        tick;
        next = 1'b0;
        e.round = 4'd0;
        e.key   = 128'h0;
        sb.push_back(e);
        key   = 128'h0;
        start = 1'b1;
        tick;
        start = 1'b0;
        popAndCompare("restart r0");
        e.round = 4'd1;
        e.key   = 128'h62636363626363636263636362636363;
        applyNext("restart r1", e);

        // start and next together: start wins.
        e.round = 4'd0;
        e.key   = fipsKey;
        sb.push_back(e);
        key   = fipsKey;
        start = 1'b1;
        next  = 1'b1;
        tick;
        start = 1'b0;
        next  = 1'b0;
        popAndCompare("start+next");

        // Async reset while in SUB, applied between clock edges.
        next = 1'b1;
        tick;
        next = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset key", round_key, 128'h0);
        checkOutput("async reset round", 128'(round), 128'h0);
        checkOutput("async reset valid", 128'(key_valid), 128'h0);
        #2;
        reset = 1'b0;
        repeat (3) tick;
        checkOutput("post reset valid", 128'(key_valid), 128'h0);
        checkOutput("post reset key", round_key, 128'h0);
        next = 1'b1;
        tick;
        next = 1'b0;
        repeat (3) tick;
        checkOutput("post reset next valid", 128'(key_valid), 128'h0);
        applyStimulus("post reset r0", fipsKey);
        applyNext("post reset r1", fipsTable[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_schedule_seq.md
Name: key_schedule_seq

Overview:
- Sequential AES-128 key expansion.
- Latches a 128-bit cipher key and produces round keys 0..10 one at a time, advancing on request.
- Feeds the key operand of the add-round-key stage: round_key holds the key for the current cipher round while the round controller uses it.
- Uses four synchronous S-box lookups (one-cycle registered read), so each new round key takes two cycles to compute.

Parameters:
- NR, 10, number of expansion rounds. Only 10 (AES-128) is supported; any other value is a configuration error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: latch key and begin a new schedule.
- key  input  128  cipher key. FIPS-197 byte order: key[127:120] is byte 0 (row 0, col 0); column-major.
- next  input  1  request the next round key. Only honoured when key_valid=1.
- round_key  output  128  current round key, same byte ordering as key. Maps directly onto the [0:3][0:3][7:0] state layout.
- round  output  4  index of round_key, 0..10.
- key_valid  output  1  round_key/round stable and usable.
- last  output  1  key_valid && round==10.

Behaviour:
- Reset (async, any time): state=IDLE, round_key=0, round=0, key_valid=0, last=0, internal S-box/Rcon registers cleared.
- States:
  - IDLE: wait for start.
  - READY: key_valid=1.
  - SUB: S-box lookups in flight.
  - EXPAND: combine words.
- start has priority in every state:
  - At the sampling edge: round_key<=key, round<=0, state<=READY.
  - key_valid=1 from the next cycle.
  - An in-flight SUB/EXPAND is abandoned.
- READY, next=1 and round<10, sampled at edge k:
  - key_valid<=0, state<=SUB.
  - S-box inputs are RotWord(w3), where w3 = round_key[31:0].
- SUB: at edge k+1 the registered S-box outputs give SubWord(RotWord(w3)); state<=EXPAND.
- EXPAND, at edge k+2:
  - t = SubWord ^ {Rcon[round+1],24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - round_key<={w0',w1',w2',w3'}, round<=round+1, key_valid<=1, state<=READY.
- Latency: key_valid low for exactly 2 cycles. The new key is valid on the cycle after edge k+2.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Ignored cases (no state change):
  - next while round==10: round_key/round hold; key_valid stays 1.
  - next in IDLE, SUB or EXPAND: request dropped, not queued.
- start and next asserted together: start wins.
- key input is only sampled on start. Changes at other times have no effect.
- Outputs are registered, except last, which is a combinational AND of registers.
- round wraps never. After 10 it stays until start or reset.
- Reset asserted mid-expansion: immediate return to reset values, with no partial update of round_key.

Test Plan:
- Reset check: hold reset 3 cycles, no start -> round_key=0, round=0, key_valid=0, last=0. Pulse next -> still 0/invalid.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: start, then next -> round 1 = a0fafe1788542cb123a339392a6c7605; key_valid low exactly 2 cycles. Second next -> round 2 = f2c295f27a96b9435935807a7359f67f.
- Full schedule: issue next whenever key_valid=1 -> round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with last=1. An extra next leaves round=10 and the key unchanged.
- Restart mid-expansion: start with key=0 one cycle after a next -> round=0, round_key=0, key_valid=1 next cycle. A following next -> round 1 = 62636363626363636263636362636363.
- Async reset during SUB: assert reset between clock edges -> outputs 0 immediately, without waiting for clk. After release, IDLE until start.
- Ignored next: next during SUB/EXPAND and next held high over several cycles -> exactly one round advance per READY-state sample, with no skipped rounds.
